// File: rtl/lsu_memory_stage_if.sv
// Data-memory and UART bus bundle between the memory stage (master)
// and the memory/peripheral side (slave).
interface lsu_memory_stage_if #(
  parameter int UART_SPAN = 16
);
  localparam int AW = $clog2(UART_SPAN);

  logic [31:0]   dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [3:0]    dmem_wstrb;
  logic          dmem_we;
  logic [31:0]   dmem_rdata;
  logic          uart_req;
  logic          uart_we;
  logic [AW-1:0] uart_addr;
  logic [7:0]    uart_wdata;
  logic          uart_ack;
  logic [7:0]    uart_rdata;

  modport master (
    output dmem_addr, dmem_wdata, dmem_wstrb, dmem_we,
    output uart_req, uart_we, uart_addr, uart_wdata,
    input  dmem_rdata, uart_ack, uart_rdata
  );

  modport slave (
    input  dmem_addr, dmem_wdata, dmem_wstrb, dmem_we,
    input  uart_req, uart_we, uart_addr, uart_wdata,
    output dmem_rdata, uart_ack, uart_rdata
  );
endinterface

// File: rtl/lsu_memory_stage.sv
// Memory stage: data-memory loads/stores, memory-mapped UART access with
// timeout, misalignment detection and the registered writeback outputs.
module lsu_memory_stage #(
  parameter logic [31:0] UART_BASE      = 32'h8000_0000,
  parameter int          UART_SPAN      = 16,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_memory_write,
  input  logic [31:0] alu_memory_write,
  input  logic [31:0] read_data_2_write,
  input  logic [4:0]  write_register_memory_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  lsu_memory_stage_if.master bus,
  output logic        stall,
  output logic        bus_error,
  output logic [31:0] pc_wb,
  output logic [31:0] alu_wb,
  output logic [31:0] load_data_wb,
  output logic [4:0]  rd_wb,
  output logic        load_valid_wb
);
  localparam int          AW        = $clog2(UART_SPAN);
  localparam int          CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] UART_MASK = ~(32'(UART_SPAN) - 32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DMEM_RD, S_UART_WAIT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr, r_pc;
  logic [4:0]    r_rd;
  logic [1:0]    r_size;
  logic          r_uns, r_load;

  logic          w_idle, w_req, w_uart, w_misal;
  logic          w_dmem_ld, w_dmem_st, w_uart_go, w_ack, w_tmo;
  logic [31:0]   w_addr;

  // Select and extend the addressed lane of a read word.
  function automatic logic [31:0] f_ext(input logic [31:0] w, input logic [1:0] off,
                                        input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    logic [31:0] r;
    s = w >> {off, 3'b000};
    case (sz)
      2'b00:   r = uns ? {24'b0, s[7:0]}  : {{24{s[7]}},  s[7:0]};
      2'b01:   r = uns ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Request decode; only meaningful while IDLE.
  always_comb begin
    w_idle    = (r_state == S_IDLE);
    w_req     = mem_read | mem_write;
    w_uart    = ((alu_memory_write & UART_MASK) == UART_BASE);
    w_misal   = w_req & ~w_uart &
                ((mem_size == 2'b01) ? alu_memory_write[0] :
                 mem_size[1]         ? (alu_memory_write[1:0] != 2'b00) : 1'b0);
    w_dmem_st = w_idle & mem_write & ~w_uart & ~w_misal;
    w_dmem_ld = w_idle & mem_read & ~mem_write & ~w_uart & ~w_misal;
    w_uart_go = w_idle & w_req & w_uart;
    w_ack     = (r_state == S_UART_WAIT) & bus.uart_ack;
    w_tmo     = (r_state == S_UART_WAIT) & ~bus.uart_ack & (r_cnt == CNT_LAST);
    stall     = w_dmem_ld | w_uart_go | ((r_state == S_UART_WAIT) & ~w_ack & ~w_tmo);
    bus_error = (w_idle & w_misal) | w_tmo;
    w_addr    = w_idle ? alu_memory_write : r_addr;
  end

  // Data-memory drive: word address, lane-replicated data, strobes only on a store.
  always_comb begin
    bus.dmem_addr = {w_addr[31:2], 2'b00};
    bus.dmem_we   = w_dmem_st;
    case (mem_size)
      2'b00: begin
        bus.dmem_wdata = {4{read_data_2_write[7:0]}};
        bus.dmem_wstrb = 4'b0001 << alu_memory_write[1:0];
      end
      2'b01: begin
        bus.dmem_wdata = {2{read_data_2_write[15:0]}};
        bus.dmem_wstrb = 4'b0011 << alu_memory_write[1:0];
      end
      default: begin
        bus.dmem_wdata = read_data_2_write;
        bus.dmem_wstrb = 4'hF;
      end
    endcase
    if (!w_dmem_st) bus.dmem_wstrb = 4'h0;
  end

  // Control FSM with registered UART drive and writeback registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_pc           <= '0;
      r_rd           <= '0;
      r_size         <= '0;
      r_uns          <= 1'b0;
      r_load         <= 1'b0;
      bus.uart_req   <= 1'b0;
      bus.uart_we    <= 1'b0;
      bus.uart_addr  <= '0;
      bus.uart_wdata <= '0;
      pc_wb          <= '0;
      alu_wb         <= '0;
      load_data_wb   <= '0;
      rd_wb          <= '0;
      load_valid_wb  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_addr <= alu_memory_write;
          r_pc   <= pc_memory_write;
          r_rd   <= write_register_memory_write;
          r_size <= mem_size;
          r_uns  <= load_unsigned;
          r_load <= mem_read & ~mem_write;
          r_cnt  <= '0;
          if (w_uart_go) begin
            r_state        <= S_UART_WAIT;
            bus.uart_req   <= 1'b1;
            bus.uart_we    <= mem_write;
            bus.uart_addr  <= alu_memory_write[AW-1:0];
            bus.uart_wdata <= read_data_2_write[7:0];
          end else if (w_dmem_ld) begin
            r_state <= S_DMEM_RD;
          end else begin
            // no request, dmem store or misaligned access: single-cycle pass-through
            pc_wb         <= pc_memory_write;
            alu_wb        <= alu_memory_write;
            rd_wb         <= w_misal ? 5'd0 : write_register_memory_write;
            load_data_wb  <= '0;
            load_valid_wb <= 1'b0;
          end
        end
        S_DMEM_RD: begin
          pc_wb         <= r_pc;
          alu_wb        <= r_addr;
          rd_wb         <= r_rd;
          load_data_wb  <= f_ext(bus.dmem_rdata, r_addr[1:0], r_size, r_uns);
          load_valid_wb <= 1'b1;
          r_state       <= S_IDLE;
        end
        S_UART_WAIT: begin
          if (w_ack) begin
            bus.uart_req  <= 1'b0;
            pc_wb         <= r_pc;
            alu_wb        <= r_addr;
            rd_wb         <= r_rd;
            load_data_wb  <= r_load ? f_ext({24'b0, bus.uart_rdata}, 2'b00, 2'b00, r_uns) : '0;
            load_valid_wb <= r_load;
            r_state       <= S_IDLE;
          end else if (w_tmo) begin
            // abandoned access: suppress the register write
            bus.uart_req  <= 1'b0;
            pc_wb         <= r_pc;
            alu_wb        <= r_addr;
            rd_wb         <= 5'd0;
            load_data_wb  <= '0;
            load_valid_wb <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_memory_stage.sv
// Self-checking bench for lsu_memory_stage: directed cases plus random
// transactions compared against a transaction-level reference model.
module tb_lsu_memory_stage;
  localparam int          UART_SPAN = 16;
  localparam int          TMO       = 255;
  localparam logic [31:0] UBASE     = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_memory_write = '0, alu_memory_write = '0, read_data_2_write = '0;
  logic [4:0]  write_register_memory_write = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
  logic [1:0]  mem_size = '0;
  logic        stall, bus_error, load_valid_wb;
  logic [31:0] pc_wb, alu_wb, load_data_wb;
  logic [4:0]  rd_wb;

  lsu_memory_stage_if #(.UART_SPAN(UART_SPAN)) bus ();

  lsu_memory_stage #(.UART_BASE(UBASE), .UART_SPAN(UART_SPAN), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .pc_memory_write(pc_memory_write), .alu_memory_write(alu_memory_write),
    .read_data_2_write(read_data_2_write),
    .write_register_memory_write(write_register_memory_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .load_unsigned(load_unsigned), .bus(bus),
    .stall(stall), .bus_error(bus_error), .pc_wb(pc_wb), .alu_wb(alu_wb),
    .load_data_wb(load_data_wb), .rd_wb(rd_wb), .load_valid_wb(load_valid_wb)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] e_pc = '0, e_alu = '0, e_ld = '0;
  logic [4:0]  e_rd = '0;
  logic        e_lv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_wb(input string tag);
    chk({tag, ".pc_wb"},  pc_wb,  e_pc);
    chk({tag, ".alu_wb"}, alu_wb, e_alu);
    chk({tag, ".rd_wb"},  {27'b0, rd_wb}, {27'b0, e_rd});
    chk({tag, ".ld_wb"},  load_data_wb, e_ld);
    chk({tag, ".lv_wb"},  {31'b0, load_valid_wb}, {31'b0, e_lv});
  endtask

  // Load result from the rules: shift lane down, mask to width, extend.
  function automatic logic [31:0] ld_model(input logic [31:0] w, input int off,
                                           input int nbytes, input bit uns);
    logic [31:0] v;
    v = w >> (8 * off);
    if (nbytes == 1) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (nbytes == 2) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One complete transaction from IDLE back to IDLE, checked cycle by cycle.
  task automatic do_txn(input string tag, input bit rdq, input bit wrq,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] sz, input bit uns, input logic [4:0] rd,
                        input int delay, input logic [31:0] rdata);
    logic [31:0] pc, exp_strb, exp_wd;
    int nbytes, off, n;
    bit is_uart, misal, acked, done;
    pc      = $urandom;
    nbytes  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off     = int'(addr % 4);
    is_uart = (addr >= UBASE) && (addr < UBASE + UART_SPAN);
    misal   = (rdq || wrq) && !is_uart && ((addr % nbytes) != 0);
    exp_strb = (nbytes == 4) ? 32'hF : (((1 << nbytes) - 1) << off);
    exp_wd   = (nbytes == 1) ? (data & 32'hFF) * 32'h0101_0101 :
               (nbytes == 2) ? (data & 32'hFFFF) * 32'h0001_0001 : data;
    pc_memory_write = pc; alu_memory_write = addr; read_data_2_write = data;
    write_register_memory_write = rd; mem_read = rdq; mem_write = wrq;
    mem_size = sz; load_unsigned = uns;
    #1;
    if (!(rdq || wrq) || (wrq && !is_uart && !misal)) begin
      chk({tag, ".stall"}, {31'b0, stall}, 32'd0);
      chk({tag, ".berr"},  {31'b0, bus_error}, 32'd0);
      chk({tag, ".we"},    {31'b0, bus.dmem_we}, {31'b0, wrq});
      if (wrq) begin
        chk({tag, ".strb"},  {28'b0, bus.dmem_wstrb}, exp_strb);
        chk({tag, ".wdata"}, bus.dmem_wdata, exp_wd);
        chk({tag, ".daddr"}, bus.dmem_addr, addr - off);
      end
      tick();
      e_pc = pc; e_alu = addr; e_rd = rd; e_ld = '0; e_lv = 1'b0;
      chk_wb(tag);
    end else if (misal) begin
      chk({tag, ".stall"}, {31'b0, stall}, 32'd0);
      chk({tag, ".berr"},  {31'b0, bus_error}, 32'd1);
      chk({tag, ".we"},    {31'b0, bus.dmem_we}, 32'd0);
      tick();
      e_pc = pc; e_alu = addr; e_rd = '0; e_ld = '0; e_lv = 1'b0;
      chk_wb(tag);
    end else if (!is_uart) begin
      chk({tag, ".stall"}, {31'b0, stall}, 32'd1);
      chk({tag, ".we"},    {31'b0, bus.dmem_we}, 32'd0);
      chk({tag, ".daddr"}, bus.dmem_addr, addr - off);
      tick();
      bus.dmem_rdata = rdata;
      #1;
      chk({tag, ".stall2"}, {31'b0, stall}, 32'd0);
      chk_wb({tag, ".hold"});
      tick();
      e_pc = pc; e_alu = addr; e_rd = rd; e_ld = ld_model(rdata, off, nbytes, uns); e_lv = 1'b1;
      chk_wb(tag);
    end else begin
      chk({tag, ".stall"}, {31'b0, stall}, 32'd1);
      chk({tag, ".req0"},  {31'b0, bus.uart_req}, 32'd0);
      tick();
      n = 0; acked = 1'b0; done = 1'b0;
      while (!done) begin
        if (n == delay) begin
          bus.uart_ack = 1'b1; bus.uart_rdata = rdata[7:0]; acked = 1'b1;
        end
        #1;
        if (n == 0) begin
          chk({tag, ".req"},   {31'b0, bus.uart_req}, 32'd1);
          chk({tag, ".uaddr"}, {28'b0, bus.uart_addr}, addr - UBASE);
          chk({tag, ".uwe"},   {31'b0, bus.uart_we}, {31'b0, wrq});
          chk({tag, ".uwd"},   {24'b0, bus.uart_wdata}, data & 32'hFF);
          chk_wb({tag, ".hold"});
        end
        done = acked || (n == TMO - 1);
        chk({tag, ".wstall"}, {31'b0, stall}, {31'b0, !done});
        chk({tag, ".wberr"},  {31'b0, bus_error}, {31'b0, (done && !acked)});
        tick();
        bus.uart_ack = 1'b0;
        n++;
      end
      e_pc = pc; e_alu = addr; e_lv = 1'b0; e_ld = '0; e_rd = '0;
      if (acked) begin
        e_rd = rd;
        if (rdq && !wrq) begin
          e_lv = 1'b1;
          e_ld = ld_model({24'b0, rdata[7:0]}, 0, 1, uns);
        end
      end
      chk_wb(tag);
      chk({tag, ".reqoff"}, {31'b0, bus.uart_req}, 32'd0);
    end
  endtask

  initial begin
    bus.dmem_rdata = '0; bus.uart_ack = 1'b0; bus.uart_rdata = '0;
    #2;
    chk("rst.stall", {31'b0, stall}, 32'd0);
    chk("rst.req",   {31'b0, bus.uart_req}, 32'd0);
    chk_wb("rst");
    tick();
    reset = 1'b0;

    // directed cases
    do_txn("lw",   1, 0, 32'h100, 32'h0, 2'b10, 0, 5'd3, 0, 32'hDEAD_BEEF);
    do_txn("lb",   1, 0, 32'h103, 32'h0, 2'b00, 0, 5'd4, 0, 32'h80FF_FF00);
    do_txn("lbu",  1, 0, 32'h103, 32'h0, 2'b00, 1, 5'd5, 0, 32'h80FF_FF00);
    do_txn("lh",   1, 0, 32'h102, 32'h0, 2'b01, 0, 5'd6, 0, 32'h8001_7FFF);
    do_txn("sh",   0, 1, 32'h102, 32'h1234_ABCD, 2'b01, 0, 5'd0, 0, 32'h0);
    do_txn("sb",   0, 1, 32'h101, 32'h0000_00A5, 2'b00, 0, 5'd0, 0, 32'h0);
    do_txn("sw11", 0, 1, 32'h104, 32'hCAFE_F00D, 2'b11, 0, 5'd0, 0, 32'h0);
    do_txn("rw",   1, 1, 32'h108, 32'h5555_AAAA, 2'b10, 0, 5'd7, 0, 32'h0);
    do_txn("usb",  0, 1, 32'h8000_0004, 32'h1234_ABCD, 2'b00, 0, 5'd0, 3, 32'h0);
    do_txn("ulb",  1, 0, 32'h8000_000F, 32'h0, 2'b10, 0, 5'd9, 1, 32'h0000_00F0);
    do_txn("utmo", 1, 0, 32'h8000_0000, 32'h0, 2'b10, 0, 5'd10, 1000, 32'h0);
    do_txn("mlw",  1, 0, 32'h102, 32'h0, 2'b10, 0, 5'd11, 0, 32'h0);
    do_txn("msh",  0, 1, 32'h203, 32'h0, 2'b01, 0, 5'd0, 0, 32'h0);

    // random transactions
    for (int i = 0; i < 80; i++) begin
      int kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 3));
      a = (kind == 3) ? (UBASE | $urandom_range(0, UART_SPAN - 1)) : ($urandom & 32'h0000_FFFF);
      do_txn($sformatf("rnd%0d", i), (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1),
             (kind == 1), a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom), int'($urandom_range(0, 5)), $urandom);
      if (kind == 3 && !mem_read) begin
        // a kind-3 draw with no read bit becomes a UART store next time
        do_txn($sformatf("rndw%0d", i), 0, 1, a, $urandom, 2'b00, 0, 5'($urandom),
               int'($urandom_range(0, 5)), 32'h0);
      end
    end

    // reset in the middle of a UART wait
    pc_memory_write = 32'h44; alu_memory_write = UBASE; write_register_memory_write = 5'd12;
    mem_read = 1'b1; mem_write = 1'b0;
    tick();
    tick();
    chk("mid.req", {31'b0, bus.uart_req}, 32'd1);
    mem_read = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid.req0",  {31'b0, bus.uart_req}, 32'd0);
    chk("mid.stall", {31'b0, stall}, 32'd0);
    e_pc = '0; e_alu = '0; e_rd = '0; e_ld = '0; e_lv = 1'b0;
    chk_wb("mid");
    tick();
    reset = 1'b0;
    do_txn("post", 0, 1, 32'h300, 32'h0BAD_F00D, 2'b10, 0, 5'd1, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
